// File: rtl/tpu_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_layer_sequencer
//
// Control sequencer for an N-layer fully-connected inference pipeline. It runs
// the layer engines one at a time. Each layer gets a one-cycle reset pulse and
// then an enable. The sequencer waits for that layer's done and then chains to
// the next layer. After the last layer it latches the argmax class index and
// raises done. layer_sel steers the shared weight ROM / MultAdder muxes.
//
// Optional build macro: SEQ_TIMEOUT_EN
//   Defined   : adds a TO_W-bit per-layer watchdog. If a layer stays in RUN
//               for TIMEOUT_CYCLES cycles without done, the run aborts.
//               timeout, done and num_out = all ones are reported.
//   Undefined : no watchdog is built, timeout is tied low, and RUN waits
//               indefinitely.
//
// Ports:
//   clk             in   system clock, rising edge
//   iRst_n          in   asynchronous active-low reset
//   ena             in   clock enable; low freezes all state and outputs
//   start           in   start request, sampled in IDLE/DONE only
//   layer_done      in   [NUM_LAYERS] per-layer done (only active bit observed)
//   layer_overflow  in   [NUM_LAYERS] per-layer overflow, sampled with done
//   class_idx       in   [IDX_W] argmax of the final layer output
//   layer_ena       out  [NUM_LAYERS] one-hot enable of the active layer
//   layer_rstn      out  [NUM_LAYERS] active-low per-layer reset pulse
//   layer_sel       out  [SEL_W] index of the active layer
//   num_out         out  [IDX_W] latched classification result
//   overflow        out  sticky OR of completed-layer overflows of this run
//   busy            out  run in progress
//   done            out  result valid until the next accepted start
//   timeout         out  watchdog abort flag
// -----------------------------------------------------------------------------
module tpu_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int SEL_W          = 4,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input  logic                  clk,
  input  logic                  iRst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [NUM_LAYERS-1:0] layer_overflow,
  input  logic [IDX_W-1:0]      class_idx,
  output logic [NUM_LAYERS-1:0] layer_ena,
  output logic [NUM_LAYERS-1:0] layer_rstn,
  output logic [SEL_W-1:0]      layer_sel,
  output logic [IDX_W-1:0]      num_out,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LRST = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LAYERS - 1);

  // Reject parameter sets that cannot be addressed or counted.
  if ((NUM_LAYERS < 1) || (NUM_LAYERS > 16) || (((NUM_LAYERS - 1) >> SEL_W) != 0)) begin : g_bad_layers
    $error("tpu_layer_sequencer: NUM_LAYERS out of range or SEL_W too narrow");
  end
  if ((TO_W < 1) || (TIMEOUT_CYCLES < 1) || ((TIMEOUT_CYCLES >> TO_W) != 0)) begin : g_bad_timeout
    $error("tpu_layer_sequencer: TIMEOUT_CYCLES does not fit TO_W");
  end

  // One-hot decode of a layer index.
  function automatic logic [NUM_LAYERS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_LAYERS-1:0] v;
    v = {NUM_LAYERS{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      v[i] = (sel == SEL_W'(i));
    end
    return v;
  endfunction

  logic [1:0]            state_r, state_s;
  logic [SEL_W-1:0]      sel_r, sel_s, nxt_sel_s;
  logic [NUM_LAYERS-1:0] ena_r, ena_s;
  logic [NUM_LAYERS-1:0] rstn_r, rstn_s;
  logic [NUM_LAYERS-1:0] cur_oh_s;
  logic [IDX_W-1:0]      num_r, num_s;
  logic                  ovf_r, ovf_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  act_done_s, act_ovf_s;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wd_r, wd_s;
  logic            to_r, to_s;
`endif

  // Only the active layer's done/overflow bits are ever looked at.
  assign cur_oh_s   = sel_onehot(sel_r);
  assign act_done_s = |(layer_done & cur_oh_s);
  assign act_ovf_s  = |(layer_overflow & cur_oh_s);
  assign nxt_sel_s  = sel_r + SEL_W'(1);

  // Next-state and next-output computation for the layer sequencing FSM.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    ena_s   = ena_r;
    rstn_s  = {NUM_LAYERS{1'b1}};
    num_s   = num_r;
    ovf_s   = ovf_r;
    busy_s  = busy_r;
    done_s  = done_r;
`ifdef SEQ_TIMEOUT_EN
    wd_s    = wd_r;
    to_s    = to_r;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          // num_out deliberately keeps the previous result until completion.
          state_s = S_LRST;
          sel_s   = {SEL_W{1'b0}};
          ena_s   = sel_onehot({SEL_W{1'b0}});
          rstn_s  = ~sel_onehot({SEL_W{1'b0}});
          busy_s  = 1'b1;
          done_s  = 1'b0;
          ovf_s   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          to_s    = 1'b0;
`endif
        end else begin
          ena_s   = {NUM_LAYERS{1'b0}};
        end
      end
      S_LRST: begin
        // The reset pulse is in flight this cycle; layer_done is not trusted yet.
        state_s = S_RUN;
`ifdef SEQ_TIMEOUT_EN
        wd_s    = {TO_W{1'b0}};
`endif
      end
      S_RUN: begin
        if (act_done_s) begin
          ovf_s = ovf_r | act_ovf_s;
          if (sel_r == LAST_SEL) begin
            num_s   = class_idx;
            ena_s   = {NUM_LAYERS{1'b0}};
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = S_DONE;
          end else begin
            // Old enable drops on the same edge the new one rises.
            sel_s   = nxt_sel_s;
            ena_s   = sel_onehot(nxt_sel_s);
            rstn_s  = ~sel_onehot(nxt_sel_s);
            state_s = S_LRST;
          end
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (wd_r == WD_LAST) begin
            // Abort: all-ones result marks the output as invalid.
            ena_s   = {NUM_LAYERS{1'b0}};
            to_s    = 1'b1;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            num_s   = {IDX_W{1'b1}};
            state_s = S_DONE;
          end else begin
            wd_s    = wd_r + TO_W'(1);
          end
`else
          state_s = S_RUN;
`endif
        end
      end
      default: begin
        state_s = S_IDLE;
        ena_s   = {NUM_LAYERS{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; ena low holds everything.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r <= S_IDLE;
      sel_r   <= {SEL_W{1'b0}};
      ena_r   <= {NUM_LAYERS{1'b0}};
      rstn_r  <= {NUM_LAYERS{1'b1}};
      num_r   <= {IDX_W{1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (ena) begin
      state_r <= state_s;
      sel_r   <= sel_s;
      ena_r   <= ena_s;
      rstn_r  <= rstn_s;
      num_r   <= num_s;
      ovf_r   <= ovf_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counter and abort flag registers.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      wd_r <= {TO_W{1'b0}};
      to_r <= 1'b0;
    end else if (ena) begin
      wd_r <= wd_s;
      to_r <= to_s;
    end
  end
  assign timeout = to_r;
`else
  assign timeout = 1'b0;
`endif

  assign layer_ena  = ena_r;
  assign layer_rstn = rstn_r;
  assign layer_sel  = sel_r;
  assign num_out    = num_r;
  assign overflow   = ovf_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tpu_layer_sequencer (NUM_LAYERS = 3).
// Each run is planned as a timeline. Layer k enters its reset cycle at
// t_start[k] and spends dur[k] cycles in RUN, with done in the last of them.
// The next layer starts at t_start[k] + 1 + dur[k]. The result appears at
// t_start[NL]. Expected outputs per cycle come from that timeline.
// -----------------------------------------------------------------------------
module tb_tpu_layer_sequencer;

  localparam int NL     = 3;
  localparam int SEL_W  = 4;
  localparam int IDX_W  = 4;
  localparam int TO_CYC = 20;
  localparam int TO_W   = 16;

  logic             clk = 1'b0;
  logic             iRst_n;
  logic             ena;
  logic             start;
  logic [NL-1:0]    layer_done;
  logic [NL-1:0]    layer_overflow;
  logic [IDX_W-1:0] class_idx;
  logic [NL-1:0]    layer_ena;
  logic [NL-1:0]    layer_rstn;
  logic [SEL_W-1:0] layer_sel;
  logic [IDX_W-1:0] num_out;
  logic             overflow;
  logic             busy;
  logic             done;
  logic             timeout;

  always #5 clk = ~clk;

  tpu_layer_sequencer #(
    .NUM_LAYERS(NL), .SEL_W(SEL_W), .IDX_W(IDX_W),
    .TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_W)
  ) u_dut (
    .clk(clk), .iRst_n(iRst_n), .ena(ena), .start(start),
    .layer_done(layer_done), .layer_overflow(layer_overflow), .class_idx(class_idx),
    .layer_ena(layer_ena), .layer_rstn(layer_rstn), .layer_sel(layer_sel),
    .num_out(num_out), .overflow(overflow), .busy(busy), .done(done), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  int               t_start [0:NL];
  int               dur     [0:NL-1];
  logic [NL-1:0]    ovf_bits;
  logic [IDX_W-1:0] model_num;
  logic [IDX_W-1:0] final_num;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".layer_ena"}, 32'(layer_ena), 32'(0));
    chk({tag, ".layer_rstn"}, 32'(layer_rstn), 32'((1 << NL) - 1));
    chk({tag, ".layer_sel"}, 32'(layer_sel), 32'(0));
    chk({tag, ".num_out"}, 32'(num_out), 32'(0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(0));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
    chk({tag, ".done"}, 32'(done), 32'(0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(0));
  endtask

  function automatic int active_layer(input int c);
    int k = 0;
    for (int j = 0; j < NL; j++) if (t_start[j] <= c) k = j;
    return k;
  endfunction

  // Compare every output against the timeline for cycle c of the current run.
  task automatic check_cycle(input int c);
    logic [NL-1:0]    e_ena, e_rstn;
    logic [IDX_W-1:0] e_num;
    logic             e_ovf, e_busy, e_done;
    int               e_sel, k;
    e_ovf = 1'b0;
    for (int j = 0; j < NL; j++) if (t_start[j+1] <= c) e_ovf |= ovf_bits[j];
    if (c >= t_start[NL]) begin
      e_ena = '0; e_rstn = '1; e_sel = NL - 1; e_num = final_num; e_busy = 1'b0; e_done = 1'b1;
    end else begin
      k = active_layer(c);
      e_ena = '0; e_ena[k] = 1'b1;
      e_rstn = (c == t_start[k]) ? ~e_ena : '1;
      e_sel = k; e_num = model_num; e_busy = 1'b1; e_done = 1'b0;
    end
    chk($sformatf("layer_ena@c%0d", c), 32'(layer_ena), 32'(e_ena));
    chk($sformatf("layer_rstn@c%0d", c), 32'(layer_rstn), 32'(e_rstn));
    chk($sformatf("layer_sel@c%0d", c), 32'(layer_sel), 32'(e_sel));
    chk($sformatf("num_out@c%0d", c), 32'(num_out), 32'(e_num));
    chk($sformatf("overflow@c%0d", c), 32'(overflow), 32'(e_ovf));
    chk($sformatf("busy@c%0d", c), 32'(busy), 32'(e_busy));
    chk($sformatf("done@c%0d", c), 32'(done), 32'(e_done));
    chk($sformatf("timeout@c%0d", c), 32'(timeout), 32'(0));
  endtask

  // Inputs for cycle c: random noise everywhere except the active layer's done.
  task automatic drive_cycle(input int c, input bit hold);
    int k;
    layer_done     = NL'($urandom);
    layer_overflow = NL'($urandom);
    class_idx      = IDX_W'($urandom);
    start          = hold ? 1'b1 : 1'($urandom_range(0, 1));
    if (c >= t_start[NL]) begin
      start = hold;
    end else begin
      k = active_layer(c);
      if (c == t_start[k] + dur[k]) begin
        layer_done[k]     = 1'b1;
        layer_overflow[k] = ovf_bits[k];
      end else if (c != t_start[k]) begin
        layer_done[k] = 1'b0;
      end
      if (c == t_start[NL] - 1) final_num = class_idx;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_cycle(t_start[NL]);
      drive_cycle(t_start[NL], 1'b0);
    end
  endtask

  // One inference. Entered just after an edge with the DUT in IDLE or DONE.
  task automatic run_once(input int fix_dur, input int ovf_mode, input bit hold,
                          input bit freeze_last, input bit abort_mid);
    int               tt, freeze_c, abort_c;
    logic [NL-1:0]    sv_done, sv_ovf;
    logic [IDX_W-1:0] sv_cls;
    logic             sv_start;
    t_start[0] = 0;
    for (int k = 0; k < NL; k++) begin
      dur[k] = (fix_dur > 0) ? fix_dur : int'($urandom_range(1, 6));
      t_start[k+1] = t_start[k] + 1 + dur[k];
    end
    ovf_bits = (ovf_mode < 0) ? NL'($urandom) : NL'(ovf_mode);
    tt       = t_start[NL];
    freeze_c = freeze_last ? tt - 1 : -1;
    abort_c  = abort_mid ? t_start[1] + 1 : -1;
    ena = 1'b1;
    start = 1'b1;
    layer_done = NL'($urandom);
    layer_overflow = NL'($urandom);
    class_idx = IDX_W'($urandom);
    for (int c = 0; c <= tt; c++) begin
      @(posedge clk); #1;
      check_cycle(c);
      if (c == abort_c) begin
        #2 iRst_n = 1'b0;
        #1 chk_reset("abort");
        model_num = '0;
        start = 1'b0;
        @(negedge clk); iRst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset("post_abort");
        return;
      end
      drive_cycle(c, hold);
      if (c == freeze_c) begin
        sv_done = layer_done; sv_ovf = layer_overflow; sv_cls = class_idx; sv_start = start;
        ena = 1'b0;
        for (int f = 0; f < 10; f++) begin
          @(posedge clk); #1;
          check_cycle(c);
          layer_done = NL'($urandom); layer_overflow = NL'($urandom);
          class_idx = IDX_W'($urandom); start = 1'($urandom_range(0, 1));
        end
        layer_done = sv_done; layer_overflow = sv_ovf; class_idx = sv_cls; start = sv_start;
        ena = 1'b1;
      end
    end
    model_num = final_num;
  endtask

  initial begin
    iRst_n = 1'b0; ena = 1'b1; start = 1'b0;
    layer_done = '0; layer_overflow = '0; class_idx = '0;
    model_num = '0; final_num = '0;
    #12 chk_reset("por");
    @(negedge clk); iRst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("idle");

    run_once(1, 0, 1'b0, 1'b0, 1'b0);         // minimum latency, 2*NL edges
    run_once(5, 2, 1'b0, 1'b0, 1'b0);         // overflow only from layer 1
    run_once(5, 0, 1'b0, 1'b0, 1'b0);         // back-to-back, overflow cleared
    run_once(0, -1, 1'b1, 1'b0, 1'b0);        // start held high throughout
    run_once(0, -1, 1'b1, 1'b0, 1'b0);
    run_once(0, -1, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int r = 0; r < 8; r++) begin
      run_once(0, -1, 1'b0, 1'b0, 1'b0);
      if (r % 2 == 1) idle(2);
    end
    run_once(0, -1, 1'b0, 1'b1, 1'b0);        // ena low at final done
    run_once(0, -1, 1'b0, 1'b0, 1'b1);        // reset mid-run in layer 1
    run_once(0, -1, 1'b0, 1'b0, 1'b0);

    start = 1'b1; layer_done = '0; layer_overflow = '0; ena = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    for (int c = 0; c <= TO_CYC + 1; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c <= TO_CYC) begin
        chk($sformatf("wd_busy@c%0d", c), 32'(busy), 32'(1));
        chk($sformatf("wd_timeout@c%0d", c), 32'(timeout), 32'(0));
      end else begin
        chk("wd_timeout", 32'(timeout), 32'(1));
        chk("wd_done", 32'(done), 32'(1));
        chk("wd_busy", 32'(busy), 32'(0));
        chk("wd_layer_ena", 32'(layer_ena), 32'(0));
        chk("wd_num_out", 32'(num_out), 32'(4'hF));
        chk("wd_overflow", 32'(overflow), 32'(0));
      end
    end
    model_num = '1;
`else
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("nowd_done", 32'(done), 32'(0));
    chk("nowd_busy", 32'(busy), 32'(1));
    chk("nowd_timeout", 32'(timeout), 32'(0));
    chk("nowd_layer_ena", 32'(layer_ena), 32'(1));
    iRst_n = 1'b0;
    #1 chk_reset("nowd_reset");
    @(negedge clk); iRst_n = 1'b1;
    @(posedge clk); #1;
    model_num = '0;
`endif
    run_once(0, -1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
